// File: rtl/lane_deskew_pkg.sv
// Shared definitions for the four-lane deskew stage: default COM symbol,
// alignment state encoding and lane count.
package lane_deskew_pkg;

    localparam int         NUM_LANES   = 4;
    localparam logic [7:0] COM_DEFAULT = 8'hBC;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_COLLECT = 2'd1,
        ST_LOCKED  = 2'd2
    } state_e;

endpackage

// File: rtl/lane_delay_line.sv
// One lane of the deskew stage: a shift register giving taps 0..MAX_SKEW
// (tap k is the input from k cycles earlier) and a registered tap select.
// Tap 0 is the live input, so a select of 0 gives a latency of one cycle.
module lane_delay_line
    import lane_deskew_pkg::*;
#(
    parameter int W        = 9,
    parameter int MAX_SKEW = 3,
    parameter int DW       = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  din,
    input  logic [DW-1:0] sel,
    output logic [W-1:0]  dout
);

    logic [W-1:0] hist_r [1:MAX_SKEW];
    logic [W-1:0] tap_s;
    logic [W-1:0] dout_r;

    // Pick the selected tap; out-of-range selects fall back to the live input.
    always_comb begin
        tap_s = din;
        for (int k = 1; k <= MAX_SKEW; k++) begin
            tap_s = (sel == DW'(k)) ? hist_r[k] : tap_s;
        end
    end

    // Shift the history and register the selected tap onto the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= MAX_SKEW; k++) begin
                hist_r[k] <= {W{1'b0}};
            end
            dout_r <= {W{1'b0}};
        end else begin
            hist_r[1] <= din;
            for (int k = 2; k <= MAX_SKEW; k++) begin
                hist_r[k] <= hist_r[k-1];
            end
            dout_r <= tap_s;
        end
    end

    assign dout = dout_r;

endmodule

// File: rtl/lane_deskew.sv
// Four-lane deskew stage feeding byte_unstrip. COM symbols (with DK high)
// are used as alignment markers: arrival times are stamped per lane and the
// early lanes are delayed so that a COM group leaves all outputs together.
// Optional feature macro: LANE_DESKEW_ERR_CNT_EN adds an 8-bit saturating
// SKEW_ERR event counter on output ERR_CNT.
module lane_deskew
    import lane_deskew_pkg::*;
#(
    parameter int              BITS     = 8,
    parameter int              MAX_SKEW = 3,
    parameter logic [BITS-1:0] COM      = BITS'(COM_DEFAULT)
) (
    input  logic            CLK,
    input  logic            RESET_L,
    input  logic [BITS-1:0] LANE0,
    input  logic [BITS-1:0] LANE1,
    input  logic [BITS-1:0] LANE2,
    input  logic [BITS-1:0] LANE3,
    input  logic            DK_0,
    input  logic            DK_1,
    input  logic            DK_2,
    input  logic            DK_3,
    output logic [BITS-1:0] OUT_LANE0,
    output logic [BITS-1:0] OUT_LANE1,
    output logic [BITS-1:0] OUT_LANE2,
    output logic [BITS-1:0] OUT_LANE3,
    output logic            OUT_DK_0,
    output logic            OUT_DK_1,
    output logic            OUT_DK_2,
    output logic            OUT_DK_3,
    output logic            ALIGNED,
    output logic            SKEW_ERR
`ifdef LANE_DESKEW_ERR_CNT_EN
    ,
    output logic [7:0]      ERR_CNT
`endif
);

    localparam int W  = BITS + 1;
    localparam int CW = (MAX_SKEW > 1) ? $clog2(MAX_SKEW + 1) : 1;
    localparam int DW = (CW > 2) ? CW : 2;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_SKEW);

    logic [W-1:0]           in_s  [NUM_LANES];
    logic [W-1:0]           out_s [NUM_LANES];
    logic [NUM_LANES-1:0]   det_s;
    logic [NUM_LANES-1:0]   out_det_s;

    state_e                 state_r, state_nxt_s;
    logic [CW-1:0]          cnt_r, cnt_nxt_s, cur_s, max_s;
    logic [NUM_LANES-1:0]   stamped_r, stamped_nxt_s;
    logic [CW-1:0]          stamp_r     [NUM_LANES];
    logic [CW-1:0]          stamp_nxt_s [NUM_LANES];
    logic [DW-1:0]          d_r         [NUM_LANES];
    logic [DW-1:0]          d_nxt_s     [NUM_LANES];
    logic                   err_s;
    logic                   aligned_r;
    logic                   skew_err_r;

    assign in_s[0] = {DK_0, LANE0};
    assign in_s[1] = {DK_1, LANE1};
    assign in_s[2] = {DK_2, LANE2};
    assign in_s[3] = {DK_3, LANE3};

    // COM detection on the raw inputs (alignment) and on the outputs (lock check).
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            det_s[i]     = in_s[i][BITS]  && (in_s[i][BITS-1:0]  == COM);
            out_det_s[i] = out_s[i][BITS] && (out_s[i][BITS-1:0] == COM);
        end
    end

    // The delay lines see the next tap select so that a new skew setting
    // already shapes the output registered on the edge that enters LOCKED.
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        lane_delay_line #(
            .W        (W),
            .MAX_SKEW (MAX_SKEW),
            .DW       (DW)
        ) u_delay (
            .clk   (CLK),
            .rst_n (RESET_L),
            .din   (in_s[g]),
            .sel   (d_nxt_s[g]),
            .dout  (out_s[g])
        );
    end

    // Alignment FSM: next state, arrival stamping, skew computation and errors.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        stamped_nxt_s = stamped_r;
        err_s         = 1'b0;
        cur_s         = cnt_r + CNT_ONE;
        max_s         = {CW{1'b0}};
        for (int i = 0; i < NUM_LANES; i++) begin
            stamp_nxt_s[i] = stamp_r[i];
            d_nxt_s[i]     = d_r[i];
        end

        case (state_r)
            ST_SEARCH: begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    d_nxt_s[i] = {DW{1'b0}};
                end
                if (|det_s) begin
                    cnt_nxt_s     = {CW{1'b0}};
                    stamped_nxt_s = det_s;
                    for (int i = 0; i < NUM_LANES; i++) begin
                        stamp_nxt_s[i] = {CW{1'b0}};
                    end
                    if (&det_s) begin
                        state_nxt_s = ST_LOCKED;
                    end else begin
                        state_nxt_s = ST_COLLECT;
                    end
                end else begin
                    stamped_nxt_s = {NUM_LANES{1'b0}};
                    state_nxt_s   = ST_SEARCH;
                end
            end

            ST_COLLECT: begin
                cnt_nxt_s = cur_s;
                for (int i = 0; i < NUM_LANES; i++) begin
                    if (det_s[i] && !stamped_r[i]) begin
                        stamped_nxt_s[i] = 1'b1;
                        stamp_nxt_s[i]   = cur_s;
                    end else begin
                        stamped_nxt_s[i] = stamped_r[i];
                        stamp_nxt_s[i]   = stamp_r[i];
                    end
                end
                for (int i = 0; i < NUM_LANES; i++) begin
                    max_s = (stamp_nxt_s[i] > max_s) ? stamp_nxt_s[i] : max_s;
                end
                if (&stamped_nxt_s) begin
                    for (int i = 0; i < NUM_LANES; i++) begin
                        d_nxt_s[i] = DW'(max_s - stamp_nxt_s[i]);
                    end
                    state_nxt_s = ST_LOCKED;
                end else if (cur_s == CNT_LAST) begin
                    err_s         = 1'b1;
                    stamped_nxt_s = {NUM_LANES{1'b0}};
                    state_nxt_s   = ST_SEARCH;
                end else begin
                    state_nxt_s = ST_COLLECT;
                end
            end

            ST_LOCKED: begin
                if ((|out_det_s) && !(&out_det_s)) begin
                    err_s         = 1'b1;
                    stamped_nxt_s = {NUM_LANES{1'b0}};
                    state_nxt_s   = ST_SEARCH;
                    for (int i = 0; i < NUM_LANES; i++) begin
                        d_nxt_s[i] = {DW{1'b0}};
                    end
                end else begin
                    state_nxt_s = ST_LOCKED;
                end
            end

            default: begin
                state_nxt_s   = ST_SEARCH;
                stamped_nxt_s = {NUM_LANES{1'b0}};
                for (int i = 0; i < NUM_LANES; i++) begin
                    d_nxt_s[i] = {DW{1'b0}};
                end
            end
        endcase
    end

    // FSM state, stamps, delay settings and the registered status outputs.
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state_r    <= ST_SEARCH;
            cnt_r      <= {CW{1'b0}};
            stamped_r  <= {NUM_LANES{1'b0}};
            aligned_r  <= 1'b0;
            skew_err_r <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                stamp_r[i] <= {CW{1'b0}};
                d_r[i]     <= {DW{1'b0}};
            end
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            stamped_r  <= stamped_nxt_s;
            aligned_r  <= (state_nxt_s == ST_LOCKED);
            skew_err_r <= err_s;
            for (int i = 0; i < NUM_LANES; i++) begin
                stamp_r[i] <= stamp_nxt_s[i];
                d_r[i]     <= d_nxt_s[i];
            end
        end
    end

    assign OUT_LANE0 = out_s[0][BITS-1:0];
    assign OUT_LANE1 = out_s[1][BITS-1:0];
    assign OUT_LANE2 = out_s[2][BITS-1:0];
    assign OUT_LANE3 = out_s[3][BITS-1:0];
    assign OUT_DK_0  = out_s[0][BITS];
    assign OUT_DK_1  = out_s[1][BITS];
    assign OUT_DK_2  = out_s[2][BITS];
    assign OUT_DK_3  = out_s[3][BITS];
    assign ALIGNED   = aligned_r;
    assign SKEW_ERR  = skew_err_r;

`ifdef LANE_DESKEW_ERR_CNT_EN
    logic [7:0] err_cnt_r;

    // Saturating count of skew error events.
    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            err_cnt_r <= 8'h00;
        end else if (err_s && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'h01;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign ERR_CNT = err_cnt_r;
`else
    // Error counter not built in this configuration.
`endif

endmodule

// File: tb/tb_lane_deskew.sv
// Randomized scoreboard bench for lane_deskew. A reference model works on
// absolute cycle numbers: it remembers each lane's input history and the
// cycle each lane first showed COM, and predicts every output cycle.
module tb_lane_deskew;

    localparam int         NL   = 4;
    localparam int         MAXS = 3;
    localparam int         HD   = 4096;
    localparam logic [7:0] COMV = 8'hBC;

    logic       clk;
    logic       rst_l;
    logic [7:0] lane_v [NL];
    logic [3:0] dk_v;
    logic [7:0] o0, o1, o2, o3;
    logic       od0, od1, od2, od3;
    logic       aligned, skew_err;
`ifdef LANE_DESKEW_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    typedef struct packed {
        logic [31:0] sym;
        logic [3:0]  dk;
        logic        aligned;
        logic        err;
        logic [7:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur_exp;
    int   n_chk  = 0;
    int   n_pass = 0;

    // reference model state
    int         t, rst_t;
    logic [8:0] hist_mem [NL][HD];
    int         mode;          // 0 searching, 1 collecting, 2 locked
    int         start_t;
    int         first_t [NL];
    int         dd      [NL];
    int         com_at  [NL];
    int         err_cnt_m;

    lane_deskew dut (
        .CLK(clk), .RESET_L(rst_l),
        .LANE0(lane_v[0]), .LANE1(lane_v[1]), .LANE2(lane_v[2]), .LANE3(lane_v[3]),
        .DK_0(dk_v[0]), .DK_1(dk_v[1]), .DK_2(dk_v[2]), .DK_3(dk_v[3]),
        .OUT_LANE0(o0), .OUT_LANE1(o1), .OUT_LANE2(o2), .OUT_LANE3(o3),
        .OUT_DK_0(od0), .OUT_DK_1(od1), .OUT_DK_2(od2), .OUT_DK_3(od3),
        .ALIGNED(aligned), .SKEW_ERR(skew_err)
`ifdef LANE_DESKEW_ERR_CNT_EN
        , .ERR_CNT(err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    endtask

    function automatic logic [8:0] past(input int ln, input int dt);
        int tt;
        tt = t - dt;
        if (tt < rst_t) return 9'h000;
        return hist_mem[ln][tt % HD];
    endfunction

    // Predict what the outputs show after the coming clock edge.
    task automatic model_step();
        bit [3:0] det;
        bit       err;
        int       n, mx;
        exp_t     e;
        logic [8:0] v;
        err = 1'b0;
        for (int i = 0; i < NL; i++) det[i] = (past(i, 0) == {1'b1, COMV});
        if (mode == 0) begin
            for (int i = 0; i < NL; i++) dd[i] = 0;
            if (det != 4'b0000) begin
                start_t = t;
                for (int i = 0; i < NL; i++) first_t[i] = det[i] ? t : -1;
                mode = (det == 4'b1111) ? 2 : 1;
            end
        end else if (mode == 1) begin
            n = 0; mx = 0;
            for (int i = 0; i < NL; i++) begin
                if (first_t[i] < 0 && det[i]) first_t[i] = t;
                if (first_t[i] >= 0) n++;
                if (first_t[i] > mx) mx = first_t[i];
            end
            if (n == NL) begin
                for (int i = 0; i < NL; i++) dd[i] = mx - first_t[i];
                mode = 2;
            end else if (t - start_t == MAXS) begin
                err = 1'b1;
                mode = 0;
            end
        end else begin
            n = 0;
            for (int i = 0; i < NL; i++)
                if (cur_exp.dk[i] && cur_exp.sym[8*i +: 8] == COMV) n++;
            if (n > 0 && n < NL) begin
                err = 1'b1;
                mode = 0;
                for (int i = 0; i < NL; i++) dd[i] = 0;
            end
        end
        for (int i = 0; i < NL; i++) begin
            v = past(i, dd[i]);
            e.sym[8*i +: 8] = v[7:0];
            e.dk[i] = v[8];
        end
        e.aligned = (mode == 2);
        e.err = err;
        if (err && err_cnt_m < 255) err_cnt_m++;
        e.cnt = err_cnt_m[7:0];
        cur_exp = e;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        mode = 0;
        for (int i = 0; i < NL; i++) begin
            first_t[i] = -1; dd[i] = 0; com_at[i] = -1;
        end
        cur_exp = '0;
        err_cnt_m = 0;
        exp_q.delete();
    endtask

    task automatic drive_body();
        logic [7:0] sym;
        logic       dkb;
        t = t + 1;
        for (int i = 0; i < NL; i++) begin
            if (com_at[i] == t) begin
                sym = COMV; dkb = 1'b1;
            end else begin
                sym = 8'($urandom);
                dkb = 1'($urandom_range(0, 1));
                if (dkb && sym == COMV) sym = sym ^ 8'h01;
            end
            lane_v[i] = sym;
            dk_v[i] = dkb;
            hist_mem[i][t % HD] = {dkb, sym};
        end
        model_step();
    endtask

    task automatic drive_cycle();
        @(negedge clk);
        drive_body();
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before any edge.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_l = 1'b0;
        for (int i = 0; i < NL; i++) lane_v[i] = 8'h00;
        dk_v = 4'h0;
        #1;
        chk("rst_lanes", {o3, o2, o1, o0}, 32'h0);
        chk("rst_dk", {od3, od2, od1, od0}, 4'h0);
        chk("rst_aligned", aligned, 1'b0);
        chk("rst_skew_err", skew_err, 1'b0);
`ifdef LANE_DESKEW_ERR_CNT_EN
        chk("rst_err_cnt", err_cnt, 8'h00);
`endif
        model_reset();
        repeat (2) @(negedge clk);
        rst_l = 1'b1;
        rst_t = t + 1;
        drive_body();
    endtask

    // COM group with per-lane offsets (negative = lane sends no COM).
    task automatic group(input int s0, input int s1, input int s2, input int s3, input int gap);
        int s [NL];
        int mx, base;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        mx = 0; base = t + 1;
        for (int i = 0; i < NL; i++) begin
            com_at[i] = (s[i] < 0) ? -1 : base + s[i];
            if (s[i] > mx) mx = s[i];
        end
        repeat (mx + 1 + gap) drive_cycle();
        for (int i = 0; i < NL; i++) com_at[i] = -1;
    endtask

    function automatic int rand_skew();
        int r;
        r = $urandom_range(0, 11);
        if (r == 0) return -1;
        if (r == 1) return 4;
        return r % 4;
    endfunction

    // Monitor: pop one expectation per output cycle and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_lane", {o3, o2, o1, o0}, e.sym);
                chk("out_dk", {od3, od2, od1, od0}, e.dk);
                chk("aligned", aligned, e.aligned);
                chk("skew_err", skew_err, e.err);
                chk("err_with_aligned", skew_err & aligned, 1'b0);
`ifdef LANE_DESKEW_ERR_CNT_EN
                chk("err_cnt", err_cnt, e.cnt);
`endif
            end
        end
    end

    initial begin
        rst_l = 1'b1;
        dk_v = 4'h0;
        for (int i = 0; i < NL; i++) lane_v[i] = 8'h00;
        t = 0; rst_t = 1;
        model_reset();
        do_reset();
        repeat (5) drive_cycle();

        group(0, 0, 0, 0, 10);          // zero skew lock
        group(0, 0, 0, 0, 10);
        group(0, 1, 2, 3, 10);          // breaks zero-skew lock
        group(0, 1, 2, 3, 10);          // locks with d = 3/2/1/0
        group(0, 1, 2, 3, 10);
        group(0, 1, 2, 3, 10);
        group(0, 1, 3, 3, 10);          // lane2 slips one cycle
        group(0, 1, 3, 3, 10);
        group(0, 1, 3, 3, 10);
        group(0, 1, 2, 4, 12);          // lane3 too late: timeout

        repeat (40) group(rand_skew(), rand_skew(), rand_skew(), rand_skew(), $urandom_range(6, 12));

        // reset while collecting, then a clean lock
        for (int i = 0; i < NL; i++) com_at[i] = t + 1 + i;
        repeat (2) drive_cycle();
        do_reset();
        group(0, 2, 1, 3, 10);
        group(0, 2, 1, 3, 10);

`ifdef LANE_DESKEW_ERR_CNT_EN
        repeat (300) group(0, -1, -1, -1, 4);
        @(posedge clk);
        #2;
        chk("err_cnt_saturated", err_cnt, 8'hFF);
        do_reset();
`endif

        repeat (3) drive_cycle();
        @(posedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lane_deskew.md
# lane_deskew

Four-lane deskew stage between the physical lanes and `byte_unstrip`. It realigns lanes that arrive with up to `MAX_SKEW` cycles of relative delay, using the COM control symbol as the alignment marker. It then presents `byte_unstrip` with lane data and control flags, `LANE*`/`DK_*`, that are mutually aligned. It also reports lock status and skew errors.

## Interface
- `BITS`, default 8: symbol width.
- `MAX_SKEW`, default 3: largest tolerated lane-to-lane skew, in cycles.
- `COM`, default 8'hBC: alignment symbol, valid only with its DK flag high.

Ports:
- `CLK` input 1: single clock. All logic is on the rising edge.
- `RESET_L` input 1: asynchronous, active-low reset.
- `LANE0`..`LANE3` input BITS: raw lane symbols.
- `DK_0`..`DK_3` input 1: per-lane control flag (1 = K symbol).
- `OUT_LANE0`..`OUT_LANE3` output BITS: deskewed symbols, fed to `byte_unstrip`.
- `OUT_DK_0`..`OUT_DK_3` output 1: deskewed control flags.
- `ALIGNED` output 1: high while in LOCKED.
- `SKEW_ERR` output 1: one-cycle pulse on a timeout or a lock loss.

## Operation
- Each lane has a delay line with taps 0..`MAX_SKEW`, where tap k is the input from k cycles earlier.
  - The lane's 2-bit-or-wider delay register `d_i` selects the tap.
  - The selected tap is registered onto `OUT_LANEi`/`OUT_DK_i`.
- A COM detect on lane i is `DK_i==1 && LANEi==COM`.
- SEARCH:
  - All `d_i`=0 (pass-through); `ALIGNED`=0.
  - On the first cycle with any COM detect, clear the skew counter. Stamp every detecting lane with arrival 0, then go to COLLECT.
  - If all four lanes detect in that same cycle, go straight to LOCKED with all `d_i`=0.
- COLLECT:
  - The counter increments each cycle, giving arrival times 1..`MAX_SKEW`.
  - A COM on an already-stamped lane is ignored.
  - A lane's first COM is stamped with the current count.
  - When all four lanes are stamped, load `d_i` = max_stamp − stamp_i and go to LOCKED.
  - If the counter reaches `MAX_SKEW` with a lane still unstamped: pulse `SKEW_ERR`, clear the stamps and go to SEARCH.
- LOCKED:
  - `ALIGNED`=1 and the `d_i` values are frozen.
  - The lock check acts on the output side. If in any cycle some, but not all, `OUT_DK_i`/`OUT_LANEi` carry COM, this is a lock loss.
  - On a lock loss: pulse `SKEW_ERR`, set `ALIGNED`=0, zero `d_i` and go to SEARCH in the next cycle.
- Non-COM symbols pass through unchanged in every state. The block does no filtering and no insertion.

## Timing
- Reset values:
  - All `OUT_LANE*`=0, `OUT_DK_*`=0, `ALIGNED`=0, `SKEW_ERR`=0.
  - State is SEARCH; `d_i`=0; delay lines and stamps are cleared.
- Latency of lane i is 1 + `d_i` cycles. In SEARCH it is 1 cycle.
- `ALIGNED` rises on the first cycle after the transition into LOCKED is registered. New `d_i` values take effect in that same cycle.
- Once locked, a COM group entering with the recorded skew leaves on all four outputs in the same cycle.
- `SKEW_ERR` is high for exactly one cycle per event. It is never high while `ALIGNED`=1 in that same cycle.
- Asserting `RESET_L` low mid-COLLECT or mid-LOCKED returns the block to the reset values immediately, without waiting for `CLK`.

## Configuration
- `LANE_DESKEW_ERR_CNT_EN` defined:
  - Adds output port `ERR_CNT` [7:0], an 8-bit saturating count of `SKEW_ERR` pulses.
  - It saturates at 8'hFF and resets to 0.
- `LANE_DESKEW_ERR_CNT_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package holds:
  - the default COM value (8'hBC);
  - the state encoding SEARCH/COLLECT/LOCKED;
  - the lane count constant (4).
- One sub-module: `lane_delay_line`. It holds one lane of `BITS`+1 bits (symbol plus DK), with `MAX_SKEW`+1 taps and a tap-select input. It is instantiated four times.

## Test plan
- Zero skew: COM on all lanes in the same cycle → `ALIGNED`=1 after 1 cycle, all `d_i`=0, and the next COM exits all lanes in the same cycle at latency 1.
- Skew 0/1/2/3 (lane0 earliest, lane3 latest) → `d` = 3/2/1/0, and each later COM group appears on all `OUT_*` in the same cycle at latency 4 on lane0.
- Lane3 COM arrives 4 cycles after lane0 with `MAX_SKEW`=3 → `SKEW_ERR` pulses once, state returns to SEARCH, `ALIGNED` stays 0.
- After lock, lane2 is shifted one cycle later → on the next COM group `SKEW_ERR`=1 and `ALIGNED` drops; the following COM group relocks with the updated `d`.
- `RESET_L` is pulsed low during COLLECT → outputs are 0 immediately. A subsequent clean COM group locks normally.
- With `LANE_DESKEW_ERR_CNT_EN`: force 300 timeout events → `ERR_CNT` saturates at 8'hFF, and reset returns it to 0.
